// File: rtl/eth_dsp_counter_poller_if.sv
// Command bus between a poller (master) and the eth_dsp_counters slave.
// The master issues single-cycle sel strobes; the slave answers with ack and rdata.
interface intf_cmd;
    logic        sel;
    logic        rd_wr_n;
    logic [31:0] byte_addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (
        output sel, rd_wr_n, byte_addr, wdata,
        input  rdata, ack
    );

    modport slave (
        input  sel, rd_wr_n, byte_addr, wdata,
        output rdata, ack
    );
endinterface

// File: rtl/eth_dsp_counter_poller.sv
// Periodically reads the ADC then DAC counters as one coherent snapshot and reports counts/deltas.
// Optional feature macro ETH_DSP_POLL_STALL_EN adds a 'stall' output flagging two unchanged snapshots.
module eth_dsp_counter_poller #(
    parameter logic [31:0] POLL_PERIOD = 32'd1_000_000,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter logic [7:0]  ACK_TIMEOUT = 8'd64
) (
    input  logic        cmd_clock,
    input  logic        cmd_sreset,
    input  logic        enable,
    input  logic        poll_now,
    intf_cmd.master     cmd,
`ifdef ETH_DSP_POLL_STALL_EN
    output logic        stall,
`endif
    output logic [31:0] adc_count,
    output logic [31:0] dac_count,
    output logic [31:0] adc_delta,
    output logic [31:0] dac_delta,
    output logic        snap_valid,
    output logic        timeout_err,
    output logic [15:0] timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE, ISS_ADC, WT_ADC, ISS_DAC, WT_DAC, UPDATE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        poll_req_q, poll_req_d;
    logic        first_poll_q, first_poll_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] adc_tmp_q, adc_tmp_d;
    logic [31:0] dac_tmp_q, dac_tmp_d;
    logic [31:0] adc_count_q, adc_count_d;
    logic [31:0] dac_count_q, dac_count_d;
    logic [31:0] adc_delta_q, adc_delta_d;
    logic [31:0] dac_delta_q, dac_delta_d;
    logic        snap_valid_q, snap_valid_d;
    logic        timeout_err_q, timeout_err_d;
    logic [15:0] timeout_cnt_q, timeout_cnt_d;
    logic        stall_q, stall_d;

    logic        timer_wrap;
    logic        req_any;
    logic        ack_expired;
    logic [31:0] adc_new_delta;
    logic [31:0] dac_new_delta;

    always_comb begin
        state_d       = state_q;
        poll_req_d    = poll_req_q;
        first_poll_d  = first_poll_q;
        wait_cnt_d    = 8'd0;
        sel_d         = 1'b0;
        addr_d        = addr_q;
        adc_tmp_d     = adc_tmp_q;
        dac_tmp_d     = dac_tmp_q;
        adc_count_d   = adc_count_q;
        dac_count_d   = dac_count_q;
        adc_delta_d   = adc_delta_q;
        dac_delta_d   = dac_delta_q;
        snap_valid_d  = 1'b0;
        timeout_err_d = 1'b0;
        timeout_cnt_d = timeout_cnt_q;
        stall_d       = stall_q;

        timer_wrap = (timer_q == POLL_PERIOD - 32'd1);
        timer_d    = timer_wrap ? 32'd0 : timer_q + 32'd1;
        // Requests are sticky; any number arriving during a poll collapse into one.
        req_any    = poll_req_q | poll_now | (timer_wrap & enable);
        poll_req_d = req_any;

        ack_expired   = (wait_cnt_q == ACK_TIMEOUT - 8'd1);
        adc_new_delta = first_poll_q ? 32'd0 : adc_tmp_q - adc_count_q;
        dac_new_delta = first_poll_q ? 32'd0 : dac_tmp_q - dac_count_q;

        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d    = ISS_ADC;
                    poll_req_d = 1'b0;
                    sel_d      = 1'b1;
                    addr_d     = BASE_ADDR;
                end
            end
            ISS_ADC, WT_ADC: begin
                if (cmd.ack) begin
                    adc_tmp_d = cmd.rdata;
                    state_d   = ISS_DAC;
                    sel_d     = 1'b1;
                    addr_d    = BASE_ADDR + 32'd4;
                end else if (state_q == ISS_ADC) begin
                    state_d = WT_ADC;
                end else if (ack_expired) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ISS_DAC, WT_DAC: begin
                if (cmd.ack) begin
                    dac_tmp_d = cmd.rdata;
                    state_d   = UPDATE;
                end else if (state_q == ISS_DAC) begin
                    state_d = WT_DAC;
                end else if (ack_expired) begin
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            UPDATE: begin
                adc_count_d  = adc_tmp_q;
                dac_count_d  = dac_tmp_q;
                adc_delta_d  = adc_new_delta;
                dac_delta_d  = dac_new_delta;
                snap_valid_d = 1'b1;
                first_poll_d = 1'b0;
                if (!first_poll_q)
                    stall_d = (adc_new_delta == 32'd0) && (dac_new_delta == 32'd0);
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort keeps old counts; forcing first_poll stops the next delta spanning the gap.
        if ((state_q == WT_ADC || state_q == WT_DAC) && !cmd.ack && ack_expired) begin
            timeout_err_d = 1'b1;
            first_poll_d  = 1'b1;
            if (timeout_cnt_q != 16'hFFFF)
                timeout_cnt_d = timeout_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge cmd_clock) begin
        if (cmd_sreset) begin
            state_q       <= IDLE;
            timer_q       <= 32'd0;
            poll_req_q    <= 1'b0;
            first_poll_q  <= 1'b1;
            wait_cnt_q    <= 8'd0;
            sel_q         <= 1'b0;
            addr_q        <= 32'd0;
            adc_count_q   <= 32'd0;
            dac_count_q   <= 32'd0;
            adc_delta_q   <= 32'd0;
            dac_delta_q   <= 32'd0;
            snap_valid_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            timeout_cnt_q <= 16'd0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            poll_req_q    <= poll_req_d;
            first_poll_q  <= first_poll_d;
            wait_cnt_q    <= wait_cnt_d;
            sel_q         <= sel_d;
            addr_q        <= addr_d;
            adc_count_q   <= adc_count_d;
            dac_count_q   <= dac_count_d;
            adc_delta_q   <= adc_delta_d;
            dac_delta_q   <= dac_delta_d;
            snap_valid_q  <= snap_valid_d;
            timeout_err_q <= timeout_err_d;
            timeout_cnt_q <= timeout_cnt_d;
            stall_q       <= stall_d;
        end
    end

    // Snapshot staging is pure data; a reset mid-poll simply never commits it.
    always_ff @(posedge cmd_clock) begin
        adc_tmp_q <= adc_tmp_d;
        dac_tmp_q <= dac_tmp_d;
    end

    assign cmd.sel       = sel_q;
    assign cmd.rd_wr_n   = 1'b1;
    assign cmd.byte_addr = addr_q;
    assign cmd.wdata     = 32'd0;

    assign adc_count   = adc_count_q;
    assign dac_count   = dac_count_q;
    assign adc_delta   = adc_delta_q;
    assign dac_delta   = dac_delta_q;
    assign snap_valid  = snap_valid_q;
    assign timeout_err = timeout_err_q;
    assign timeout_cnt = timeout_cnt_q;

`ifdef ETH_DSP_POLL_STALL_EN
    assign stall = stall_q;
`else
    logic unused_stall;
    assign unused_stall = stall_q ^ stall_d;
`endif

endmodule

// File: tb/tb_eth_dsp_counter_poller.sv
// Directed bench for eth_dsp_counter_poller with a zero-wait counter slave model.
// The stall scenario is exercised only when ETH_DSP_POLL_STALL_EN is defined.
module tb_eth_dsp_counter_poller;
    localparam logic [31:0] BASE = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic [31:0] adc_count, dac_count, adc_delta, dac_delta;
    logic        snap_valid, timeout_err;
    logic [15:0] timeout_cnt;
`ifdef ETH_DSP_POLL_STALL_EN
    logic        stall;
`endif

    logic [31:0] adc_val = 32'd0;
    logic [31:0] dac_val = 32'd0;
    logic        dac_ack_off = 1'b0;

    int checks = 0;
    int failures = 0;

    intf_cmd cmd_if ();

    eth_dsp_counter_poller #(
        .POLL_PERIOD(32'd16),
        .BASE_ADDR  (BASE),
        .ACK_TIMEOUT(8'd64)
    ) dut (
        .cmd_clock  (clk),
        .cmd_sreset (rst),
        .enable     (enable),
        .poll_now   (poll_now),
        .cmd        (cmd_if.master),
`ifdef ETH_DSP_POLL_STALL_EN
        .stall      (stall),
`endif
        .adc_count  (adc_count),
        .dac_count  (dac_count),
        .adc_delta  (adc_delta),
        .dac_delta  (dac_delta),
        .snap_valid (snap_valid),
        .timeout_err(timeout_err),
        .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // Zero-wait slave: ack and rdata one cycle after sel.
    always @(posedge clk) begin
        if (rst) begin
            cmd_if.ack   <= 1'b0;
            cmd_if.rdata <= 32'd0;
        end else begin
            cmd_if.ack   <= cmd_if.sel && !(dac_ack_off && cmd_if.byte_addr == BASE + 32'd4);
            cmd_if.rdata <= (cmd_if.byte_addr == BASE) ? adc_val : dac_val;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; poll_now = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_poll(output bit got);
        got = 1'b0;
        @(negedge clk);
        poll_now = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            poll_now = 1'b0;
            if (snap_valid) begin
                got = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({adc_count, dac_count, adc_delta, dac_delta} !== 128'd0) begin
            failures++;
            $display("FAIL reset_counts: got %h %h %h %h, want all 0", adc_count, dac_count, adc_delta, dac_delta);
        end
        checks++;
        if ({snap_valid, timeout_err, timeout_cnt} !== 18'd0) begin
            failures++;
            $display("FAIL reset_flags: got snap=%b terr=%b tcnt=%0d, want 0", snap_valid, timeout_err, timeout_cnt);
        end
        checks++;
        if ({cmd_if.sel, cmd_if.rd_wr_n, cmd_if.byte_addr, cmd_if.wdata} !== {1'b0, 1'b1, 64'd0}) begin
            failures++;
            $display("FAIL reset_bus: got sel=%b rw=%b addr=%h wdata=%h, want 0/1/0/0",
                     cmd_if.sel, cmd_if.rd_wr_n, cmd_if.byte_addr, cmd_if.wdata);
        end
    endtask

    task automatic test_first_poll();
        int adc_idx = -1, dac_idx = -1, snap_idx = -1, sel_cycles = 0;
        bit bus_ok = 1'b1;
        adc_val = 32'd100; dac_val = 32'd50;
        @(negedge clk);
        poll_now = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            poll_now = 1'b0;
            if (cmd_if.sel) begin
                sel_cycles++;
                if (cmd_if.rd_wr_n !== 1'b1 || cmd_if.wdata !== 32'd0) bus_ok = 1'b0;
                if (cmd_if.byte_addr == BASE && adc_idx < 0) adc_idx = i;
                if (cmd_if.byte_addr == BASE + 32'd4 && dac_idx < 0) dac_idx = i;
            end
            if (snap_valid && snap_idx < 0) snap_idx = i;
        end
        checks++;
        if (adc_idx !== 0 || dac_idx !== 2) begin
            failures++;
            $display("FAIL poll_seq: adc sel at %0d dac sel at %0d, want 0 and 2", adc_idx, dac_idx);
        end
        checks++;
        if (sel_cycles !== 2 || !bus_ok) begin
            failures++;
            $display("FAIL poll_sel: sel cycles %0d bus_ok %b, want 2 and 1", sel_cycles, bus_ok);
        end
        checks++;
        if (snap_idx !== 5) begin
            failures++;
            $display("FAIL poll_latency: snap_valid at %0d, want 5 (6 cycles after poll_now)", snap_idx);
        end
        checks++;
        if ({adc_count, dac_count, adc_delta, dac_delta} !== {32'd100, 32'd50, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL poll_values: got %0d %0d %0d %0d, want 100 50 0 0", adc_count, dac_count, adc_delta, dac_delta);
        end
    endtask

    task automatic test_wrap();
        bit got;
        adc_val = 32'hFFFF_FFFE; dac_val = 32'd50;
        do_poll(got);
        checks++;
        if (got !== 1'b1 || adc_delta !== 32'hFFFF_FF9A || dac_delta !== 32'd0) begin
            failures++;
            $display("FAIL delta_neg: got snap=%b adc_delta=%h dac_delta=%h, want 1 FFFFFF9A 0", got, adc_delta, dac_delta);
        end
        adc_val = 32'h0000_0005; dac_val = 32'd60;
        do_poll(got);
        checks++;
        if (got !== 1'b1 || adc_delta !== 32'd7 || dac_delta !== 32'd10) begin
            failures++;
            $display("FAIL delta_wrap: got snap=%b adc_delta=%0d dac_delta=%0d, want 1 7 10", got, adc_delta, dac_delta);
        end
    endtask

    task automatic test_timeout();
        int terr_idx = -1, snaps = 0;
        bit got;
        dac_ack_off = 1'b1;
        adc_val = 32'd999; dac_val = 32'd999;
        @(negedge clk);
        poll_now = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            poll_now = 1'b0;
            if (timeout_err && terr_idx < 0) terr_idx = i;
            if (snap_valid) snaps++;
        end
        checks++;
        if (terr_idx !== 67 || snaps !== 0) begin
            failures++;
            $display("FAIL timeout_pulse: timeout_err at %0d snaps %0d, want 67 and 0", terr_idx, snaps);
        end
        checks++;
        if ({adc_count, dac_count, adc_delta, dac_delta} !== {32'd5, 32'd60, 32'd7, 32'd10} || timeout_cnt !== 16'd1) begin
            failures++;
            $display("FAIL timeout_hold: got %0d %0d %0d %0d cnt=%0d, want 5 60 7 10 cnt=1",
                     adc_count, dac_count, adc_delta, dac_delta, timeout_cnt);
        end
        dac_ack_off = 1'b0;
        adc_val = 32'd200; dac_val = 32'd70;
        do_poll(got);
        checks++;
        if (got !== 1'b1 || {adc_count, dac_count, adc_delta, dac_delta} !== {32'd200, 32'd70, 32'd0, 32'd0}) begin
            failures++;
            $display("FAIL timeout_recover: got snap=%b %0d %0d %0d %0d, want 1 200 70 0 0",
                     got, adc_count, dac_count, adc_delta, dac_delta);
        end
    endtask

    task automatic test_periodic();
        int polls = 0, snaps = 0;
        do_reset();
        adc_val = 32'd10; dac_val = 32'd20;
        enable = 1'b1;
        for (int i = 0; i < 120; i++) begin
            @(posedge clk); #1;
            if (i == 99) enable = 1'b0;
            if (cmd_if.sel && cmd_if.byte_addr == BASE) polls++;
            if (snap_valid) snaps++;
        end
        checks++;
        if (polls !== 6 || snaps !== 6) begin
            failures++;
            $display("FAIL periodic: polls %0d snaps %0d, want 6 and 6", polls, snaps);
        end
    endtask

    task automatic test_back_to_back();
        int polls = 0, snaps = 0;
        adc_val = 32'd10; dac_val = 32'd20;
        @(negedge clk);
        poll_now = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            poll_now = (i == 1 || i == 3);
            if (cmd_if.sel && cmd_if.byte_addr == BASE) polls++;
            if (snap_valid) snaps++;
        end
        checks++;
        if (polls !== 2 || snaps !== 2) begin
            failures++;
            $display("FAIL back_to_back: polls %0d snaps %0d, want 2 and 2", polls, snaps);
        end
        checks++;
        if (adc_delta !== 32'd0 || dac_delta !== 32'd0 || adc_count !== 32'd10) begin
            failures++;
            $display("FAIL back_to_back_vals: adc=%0d deltas %0d %0d, want 10 0 0", adc_count, adc_delta, dac_delta);
        end
    endtask

    task automatic test_reset_mid();
        int snaps = 0;
        adc_val = 32'd77; dac_val = 32'd88;
        @(negedge clk);
        poll_now = 1'b1;
        @(posedge clk); #1;
        poll_now = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (cmd_if.sel !== 1'b0 || {adc_count, dac_count, adc_delta, dac_delta} !== 128'd0) begin
            failures++;
            $display("FAIL reset_mid: sel=%b counts %0d %0d %0d %0d, want 0 and all 0",
                     cmd_if.sel, adc_count, dac_count, adc_delta, dac_delta);
        end
        rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (snap_valid || cmd_if.sel) snaps++;
        end
        checks++;
        if (snaps !== 0) begin
            failures++;
            $display("FAIL reset_mid_quiet: %0d snap/sel cycles after reset, want 0", snaps);
        end
    endtask

`ifdef ETH_DSP_POLL_STALL_EN
    task automatic test_stall();
        bit got;
        adc_val = 32'd300; dac_val = 32'd80;
        do_poll(got);
        checks++;
        if (got !== 1'b1 || stall !== 1'b0) begin
            failures++;
            $display("FAIL stall_first: snap=%b stall=%b, want 1 0", got, stall);
        end
        do_poll(got);
        checks++;
        if (got !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("FAIL stall_set: snap=%b stall=%b, want 1 1", got, stall);
        end
        dac_val = 32'd81;
        do_poll(got);
        checks++;
        if (got !== 1'b1 || stall !== 1'b0 || dac_delta !== 32'd1) begin
            failures++;
            $display("FAIL stall_clear: snap=%b stall=%b dac_delta=%0d, want 1 0 1", got, stall, dac_delta);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_poll();
        test_wrap();
        test_timeout();
        test_back_to_back();
        test_periodic();
        test_reset_mid();
`ifdef ETH_DSP_POLL_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
